// File: rtl/fe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fe_hazard_ctrl
// Purpose  : Fetch-side sequencer. Runs a RAW scoreboard that drives STALL and
//            a redirect-and-drain sequence for taken branches.
// Revision : 1.0  initial release
// ============================================================================
module fe_hazard_ctrl #(
    parameter int NUM_REGS     = 8,
    parameter int REG_W        = 3,
    parameter int WB_LAT       = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_src1,
    input  logic                id_src1_used,
    input  logic [REG_W-1:0]    id_src2,
    input  logic                id_src2_used,
    input  logic [REG_W-1:0]    id_dst,
    input  logic                id_dst_wr,
    input  logic                ex_branch_taken,
    input  logic [15:0]         ex_branch_target,
    output logic                STALL,
    output logic                BRANCH,
    output logic [15:0]         branch_instr_addr,
    output logic                id_flush,
    output logic [NUM_REGS-1:0] busy_mask
);

    localparam logic [2:0] c_wb_lat   = 3'(WB_LAT);
    localparam logic [1:0] c_flush_cy = 2'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic        branch_q, branch_d;
    logic        flush_q, flush_d;
    logic [15:0] addr_q, addr_d;
    logic [2:0]  cnt_q [NUM_REGS];
    logic [2:0]  cnt_d [NUM_REGS];

    logic src1_conflict;
    logic src2_conflict;
    logic stall;
    logic issue;
    logic in_run;

    // A source with cnt==1 still conflicts: writeback is not forwarded.
    always_comb begin
        in_run        = (state_q == ST_RUN);
        src1_conflict = id_src1_used && (id_src1 != '0) && (cnt_q[id_src1] != 3'd0);
        src2_conflict = id_src2_used && (id_src2 != '0) && (cnt_q[id_src2] != 3'd0);
        stall         = in_run && id_valid && !ex_branch_taken
                        && (src1_conflict || src2_conflict);
        issue         = in_run && id_valid && !stall && !ex_branch_taken && !flush_q;
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = (cnt_q[i] != 3'd0) ? cnt_q[i] - 3'd1 : cnt_q[i];
            if (issue && id_dst_wr && (id_dst != '0) && (id_dst == REG_W'(i)))
                cnt_d[i] = c_wb_lat;
        end
    end

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        branch_d = 1'b0;
        flush_d  = flush_q;
        addr_d   = addr_q;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    state_d  = ST_REDIRECT;
                    branch_d = 1'b1;
                    flush_d  = 1'b1;
                    addr_d   = ex_branch_target;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_DRAIN;
                drain_d = c_flush_cy;
                flush_d = 1'b1;
            end
            ST_DRAIN: begin
                if (drain_q <= 2'd1) begin
                    state_d = ST_RUN;
                    drain_d = 2'd0;
                    flush_d = 1'b0;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                drain_d = 2'd0;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= ST_RUN;
            drain_q  <= 2'd0;
            branch_q <= 1'b0;
            flush_q  <= 1'b0;
            addr_q   <= 16'h0000;
            for (int i = 0; i < NUM_REGS; i++)
                cnt_q[i] <= 3'd0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            branch_q <= branch_d;
            flush_q  <= flush_d;
            addr_q   <= addr_d;
            for (int i = 0; i < NUM_REGS; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_busy
            assign busy_mask[g] = (cnt_q[g] != 3'd0);
        end
    endgenerate

    assign STALL             = stall;
    assign BRANCH            = branch_q;
    assign branch_instr_addr = addr_q;
    assign id_flush          = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_fe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fe_hazard_ctrl
// Purpose  : Directed plus randomized bench for fe_hazard_ctrl against a
//            timestamp-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fe_hazard_ctrl;

    localparam int NUM_REGS     = 8;
    localparam int REG_W        = 3;
    localparam int WB_LAT       = 3;
    localparam int FLUSH_CYCLES = 2;

    logic                CLOCK_50 = 1'b0;
    logic                reset = 1'b1;
    logic                id_valid = 1'b0;
    logic [REG_W-1:0]    id_src1 = '0;
    logic                id_src1_used = 1'b0;
    logic [REG_W-1:0]    id_src2 = '0;
    logic                id_src2_used = 1'b0;
    logic [REG_W-1:0]    id_dst = '0;
    logic                id_dst_wr = 1'b0;
    logic                ex_branch_taken = 1'b0;
    logic [15:0]         ex_branch_target = '0;
    logic                STALL;
    logic                BRANCH;
    logic [15:0]         branch_instr_addr;
    logic                id_flush;
    logic [NUM_REGS-1:0] busy_mask;

    always #10 CLOCK_50 = ~CLOCK_50;

    fe_hazard_ctrl #(
        .NUM_REGS(NUM_REGS), .REG_W(REG_W), .WB_LAT(WB_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_dst_wr(id_dst_wr),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .STALL(STALL), .BRANCH(BRANCH), .branch_instr_addr(branch_instr_addr),
        .id_flush(id_flush), .busy_mask(busy_mask)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: time is the count of rising edges; a branch accepted at edge E
    // owns cycles E..E+FLUSH_CYCLES, and a write issued at edge E makes its
    // register busy for cycles E..E+WB_LAT-1.
    int          cyc = 0;
    int          br_edge = -100;
    int          ready [NUM_REGS];
    logic [15:0] last_addr = 16'h0000;
    bit          p_rst = 1'b1;
    bit          p_branch = 1'b0;
    bit          p_issue = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit model_in_run(input int c);
        return !(c >= br_edge && c <= br_edge + FLUSH_CYCLES);
    endfunction

    function automatic bit model_busy(input int r, input int c);
        return (r != 0) && (c < ready[r]);
    endfunction

    task automatic step(input bit r, input bit v,
                        input logic [2:0] s1, input bit u1,
                        input logic [2:0] s2, input bit u2,
                        input logic [2:0] d, input bit dw,
                        input bit tk, input logic [15:0] tgt);
        bit         run;
        bit         e_stall;
        logic [7:0] e_busy;
        @(posedge CLOCK_50);
        cyc++;
        if (p_rst) begin
            br_edge   = -100;
            last_addr = 16'h0000;
            for (int i = 0; i < NUM_REGS; i++) ready[i] = -100;
        end else begin
            if (p_branch) begin
                br_edge   = cyc;
                last_addr = ex_branch_target;
            end
            if (p_issue && id_dst_wr && id_dst != 3'd0)
                ready[int'(id_dst)] = cyc + WB_LAT;
        end
        #1;
        reset = r; id_valid = v;
        id_src1 = s1; id_src1_used = u1;
        id_src2 = s2; id_src2_used = u2;
        id_dst = d; id_dst_wr = dw;
        ex_branch_taken = tk; ex_branch_target = tgt;
        @(negedge CLOCK_50);
        run = model_in_run(cyc);
        e_busy = '0;
        for (int i = 0; i < NUM_REGS; i++) e_busy[i] = model_busy(i, cyc);
        e_stall = run && v && !tk &&
                  ((u1 && model_busy(int'(s1), cyc)) || (u2 && model_busy(int'(s2), cyc)));
        check("STALL",  32'(STALL),             32'(e_stall));
        check("BRANCH", 32'(BRANCH),            32'(cyc == br_edge));
        check("ADDR",   32'(branch_instr_addr), 32'(last_addr));
        check("FLUSH",  32'(id_flush),          32'(!run));
        check("BUSY",   32'(busy_mask),         32'(e_busy));
        p_rst    = r;
        p_branch = run && tk;
        p_issue  = run && v && !e_stall && !tk;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) ready[i] = -100;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        idle(3);
        // Write R3, then a reader of R3 held in ID until it issues.
        step(0, 1, 0, 0, 0, 0, 3, 1, 0, 16'h0);
        for (int i = 0; i < 5; i++) step(0, 1, 3, 1, 0, 0, 1, 1, 0, 16'h0);
        idle(4);
        // R0 never becomes busy.
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        step(0, 1, 0, 1, 0, 1, 4, 0, 0, 16'h0);
        idle(2);
        // Back-to-back writes of R2.
        step(0, 1, 0, 0, 0, 0, 2, 1, 0, 16'h0);
        step(0, 1, 0, 0, 0, 0, 2, 1, 0, 16'h0);
        idle(4);
        // Taken branch, with extra wrong-path branches during the sequence.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0040);
        step(0, 1, 0, 0, 0, 0, 6, 1, 1, 16'h1234);
        step(0, 1, 0, 0, 0, 0, 6, 1, 1, 16'h5678);
        idle(3);
        // Branch coincident with a RAW hazard on R5.
        step(0, 1, 0, 0, 0, 0, 5, 1, 0, 16'h0);
        step(0, 1, 5, 1, 0, 0, 7, 1, 1, 16'h0080);
        idle(5);
        // Reset while draining.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h00C0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        idle(3);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0,
                 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
